// File: rtl/main_controller.sv
// Multi-cycle RV32I control FSM: decodes the fetched word and sequences
// PC, register-file and data-RAM strobes; halts on illegal encodings.
module main_controller #(
    parameter int unsigned LOAD_WAIT = 1,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 stall,
    output logic                 pcEn,
    output logic [1:0]           pcSelect,
    output logic                 regWrite,
    output logic                 aluSrc,
    output logic                 ramRdEn,
    output logic                 ramWrEn,
    output logic                 isByte,
    output logic                 isHalf,
    output logic                 isWord,
    output logic [1:0]           memToReg,
    output logic                 halted,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] instr_retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] WAIT_LAST = 4'(LOAD_WAIT - 1);

    state_e               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic [6:0]           op_q, op_d;
    logic [2:0]           f3_q, f3_d;
    logic [CNT_WIDTH-1:0] ret_q, ret_d;

    logic is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_ialu;
    logic active;
    logic unused_bits;

    function automatic logic op_legal(input logic [6:0] op,
                                      input logic [2:0] f3);
        logic ok;
        case (op)
            OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI: ok = 1'b1;
            OP_LD, OP_ST: ok = (f3[1:0] != 2'b11);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign unused_bits = ^{instr[31:15], instr[11:7], f3_q[2]};

    assign is_ld   = (op_q == OP_LD);
    assign is_st   = (op_q == OP_ST);
    assign is_br   = (op_q == OP_BR);
    assign is_jal  = (op_q == OP_JAL);
    assign is_jalr = (op_q == OP_JALR);
    assign is_lui  = (op_q == OP_LUI);
    assign is_ialu = (op_q == OP_I);

    // Decoded controls only mean something once the fields are latched
    assign active = (state_q == S_EXEC) || (state_q == S_MEM) ||
                    (state_q == S_WB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            op_q    <= '0;
            f3_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        op_d     = op_q;
        f3_d     = f3_q;
        ret_d    = ret_q;
        pcEn     = 1'b0;
        regWrite = 1'b0;
        ramRdEn  = 1'b0;
        ramWrEn  = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (!stall) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!stall) begin
                    op_d    = instr[6:0];
                    f3_d    = instr[14:12];
                    state_d = op_legal(instr[6:0], instr[14:12])
                              ? S_EXEC : S_TRAP;
                end
            end
            S_EXEC: begin
                if (!stall) state_d = (is_ld || is_st) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (is_ld) begin
                    ramRdEn = 1'b1;
                    if (!stall) begin
                        if (wait_q == WAIT_LAST) begin
                            wait_d  = '0;
                            state_d = S_WB;
                        end else begin
                            wait_d = wait_q + 4'd1;
                        end
                    end
                end else begin
                    ramWrEn = !stall;
                    if (!stall) state_d = S_WB;
                end
            end
            S_WB: begin
                pcEn     = !stall;
                regWrite = !stall && !is_st && !is_br;
                if (!stall) begin
                    ret_d   = ret_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    always_comb begin
        aluSrc   = 1'b0;
        memToReg = 2'b00;
        pcSelect = 2'b00;
        isByte   = 1'b0;
        isHalf   = 1'b0;
        isWord   = 1'b0;
        if (active) begin
            aluSrc = is_ialu || is_ld || is_st || is_jalr;
            unique case (1'b1)
                is_ld:            memToReg = 2'b01;
                is_jal, is_jalr:  memToReg = 2'b10;
                is_lui:           memToReg = 2'b11;
                default:          memToReg = 2'b00;
            endcase
            unique case (1'b1)
                is_br:   pcSelect = 2'b01;
                is_jal:  pcSelect = 2'b10;
                is_jalr: pcSelect = 2'b11;
                default: pcSelect = 2'b00;
            endcase
            if (is_ld || is_st) begin
                isByte = (f3_q[1:0] == 2'b00);
                isHalf = (f3_q[1:0] == 2'b01);
                isWord = (f3_q[1:0] == 2'b10);
            end
        end
    end

    assign state         = state_q;
    assign instr_retired = ret_q;

endmodule

// File: tb/tb_main_controller.sv
// Randomized scoreboard bench for main_controller: a per-instruction
// phase model predicts each cycle's outputs, a monitor compares them.
module tb_main_controller;

    localparam int LW = 2;
    localparam int CW = 4;
    localparam int NCYC = 4000;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          stall;
    logic          pcEn, regWrite, aluSrc, ramRdEn, ramWrEn;
    logic          isByte, isHalf, isWord, halted;
    logic [1:0]    pcSelect, memToReg;
    logic [2:0]    state;
    logic [CW-1:0] instr_retired;

    main_controller #(.LOAD_WAIT(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .stall(stall),
        .pcEn(pcEn), .pcSelect(pcSelect), .regWrite(regWrite),
        .aluSrc(aluSrc), .ramRdEn(ramRdEn), .ramWrEn(ramWrEn),
        .isByte(isByte), .isHalf(isHalf), .isWord(isWord),
        .memToReg(memToReg), .halted(halted), .state(state),
        .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pcEn;
        logic [1:0] pcSel;
        logic       regWrite;
        logic       aluSrc;
        logic       ramRdEn;
        logic       ramWrEn;
        logic       isByte;
        logic       isHalf;
        logic       isWord;
        logic [1:0] m2r;
        logic       halted;
    } vec_t;

    typedef struct {
        vec_t          v;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sbq[$];
    vec_t          steps[$];
    logic [31:0]   directed[$];
    int            idx;
    logic [CW-1:0] mcnt;
    int            vectors = 0;
    int            miscompares = 0;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    function automatic vec_t dut_vec();
        return {state, pcEn, pcSelect, regWrite, aluSrc, ramRdEn,
                ramWrEn, isByte, isHalf, isWord, memToReg, halted};
    endfunction

    task automatic check(input string name, input vec_t act,
                         input vec_t exp, input logic [CW-1:0] acnt,
                         input logic [CW-1:0] ecnt);
        vectors++;
        if (act !== exp || acnt !== ecnt) begin
            miscompares++;
            $display("FAIL %s t=%0t: got vec=%h cnt=%0d, want vec=%h cnt=%0d",
                     name, $time, act, acnt, exp, ecnt);
        end
    endtask

    // Expected outputs of each unstalled cycle of one instruction
    task automatic build(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic       ld, st, br, legal;
        vec_t       c, s;
        op = w[6:0];
        f3 = w[14:12];
        ld = (op == OP_LD);
        st = (op == OP_ST);
        br = (op == OP_BR);
        legal = (op == OP_R) || (op == OP_I) || br || (op == OP_JAL) ||
                (op == OP_JALR) || (op == OP_LUI) ||
                ((ld || st) && f3[1:0] != 2'b11);
        steps.delete();
        s = '0;
        steps.push_back(s);
        s.st = 3'd1;
        steps.push_back(s);
        if (!legal) begin
            s = '0;
            s.st = 3'd7;
            s.halted = 1'b1;
            steps.push_back(s);
            return;
        end
        c = '0;
        c.aluSrc = (op == OP_I) || ld || st || (op == OP_JALR);
        c.m2r = ld ? 2'd1 :
                ((op == OP_JAL) || (op == OP_JALR)) ? 2'd2 :
                (op == OP_LUI) ? 2'd3 : 2'd0;
        c.pcSel = br ? 2'd1 : (op == OP_JAL) ? 2'd2 :
                  (op == OP_JALR) ? 2'd3 : 2'd0;
        if (ld || st) begin
            c.isByte = (f3[1:0] == 2'd0);
            c.isHalf = (f3[1:0] == 2'd1);
            c.isWord = (f3[1:0] == 2'd2);
        end
        s = c;
        s.st = 3'd2;
        steps.push_back(s);
        if (ld) begin
            for (int i = 0; i < LW; i++) begin
                s = c;
                s.st = 3'd3;
                s.ramRdEn = 1'b1;
                steps.push_back(s);
            end
        end
        if (st) begin
            s = c;
            s.st = 3'd3;
            s.ramWrEn = 1'b1;
            steps.push_back(s);
        end
        s = c;
        s.st = 3'd4;
        s.pcEn = 1'b1;
        s.regWrite = !(st || br);
        steps.push_back(s);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [8];
        logic [31:0] r;
        logic [6:0]  op;
        logic [2:0]  f3;
        int          k;
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI};
        r = $urandom();
        k = $urandom_range(0, 63);
        if (k == 62) op = OP_AUIPC;
        else if (k == 63) op = 7'($urandom());
        else op = ops[k % 8];
        f3 = 3'($urandom_range(0, 7));
        if ((op == OP_LD || op == OP_ST) && $urandom_range(0, 15) != 0)
            f3[1:0] = 2'($urandom_range(0, 2));
        return {r[31:15], f3, r[11:7], op};
    endfunction

    task automatic next_instr();
        logic [31:0] w;
        if (directed.size() > 0) w = directed.pop_front();
        else w = rand_instr();
        instr = w;
        build(w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        stall = 1'b0;
        reset = 1'b0;
        #1;
        check("async_reset", dut_vec(), '0, instr_retired, '0);
        @(posedge clk);
        #1;
        check("reset_hold", dut_vec(), '0, instr_retired, '0);
        @(negedge clk);
        reset = 1'b1;
        mcnt = '0;
        next_instr();
        idx = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("cycle", dut_vec(), e.v, instr_retired, e.cnt);
        end
    end

    initial begin
        vec_t cur, ex;
        exp_t item;
        int   trapcnt;
        int   mid_resets;
        reset = 1'b0;
        stall = 1'b0;
        instr = '0;
        idx = 0;
        mcnt = '0;
        trapcnt = 0;
        mid_resets = 0;
        directed = '{32'h002081B3, 32'h0000A183, 32'h00308023,
                     32'h00208463, 32'h000080E7, 32'h00000000};
        do_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            stall = (cyc > 40) && ($urandom_range(0, 3) == 0);
            cur = steps[idx];
            ex = cur;
            if (stall) begin
                ex.pcEn = 1'b0;
                ex.regWrite = 1'b0;
                ex.ramWrEn = 1'b0;
            end
            item.v = ex;
            item.cnt = mcnt;
            sbq.push_back(item);
            if (cur.st == 3'd7) begin
                trapcnt++;
            end else if (!stall) begin
                if (cur.st == 3'd4) mcnt = mcnt + 1'b1;
                idx++;
                if (idx == steps.size()) begin
                    next_instr();
                    idx = 0;
                end
            end
            if (trapcnt > 20) begin
                trapcnt = 0;
                do_reset();
            end else if (cur.st == 3'd3 && cur.ramRdEn && mid_resets < 3 &&
                         $urandom_range(0, 7) == 0) begin
                mid_resets++;
                do_reset();
            end
        end
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
